fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15, SHALL set the maximum cycles fetch_ctrl waits for mem_ready per memory request.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  level; 1 = free-running execution.
REQ-005 step  input  1  one-cycle pulse; execute exactly one instruction.
REQ-006 pc  input  8  current PC value from the program counter.
REQ-007 mem_ready  input  1  memory has valid mem_rdata this cycle.
REQ-008 mem_rdata  input  8  memory read data.
REQ-009 mem_req  output  1  read request to memory.
REQ-010 mem_addr  output  8  read address; SHALL equal pc.
REQ-011 load_pc  output  1  drives the program counter LOAD_PC.
REQ-012 incr_pc  output  1  drives the program counter INCR_PC.
REQ-013 addr  output  8  jump target; drives the program counter ADDR.
REQ-014 ir  output  8  last fetched opcode byte.
REQ-015 halted  output  1  controller is in HALT.
REQ-016 err  output  1  halt caused by an illegal opcode or a timeout.
REQ-017 icount  output  8  count of retired instructions.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, FETCH_OP, JUMP and HALT.
REQ-019 Opcode field SHALL be ir[7:6]: 00 NOP, 01 JMP (two bytes, operand at pc+1), 11 HALT, 10 illegal.
REQ-020 IDLE: a step pulse, or run=1, SHALL move to FETCH; run and step together SHALL be treated as run.
REQ-021 FETCH/FETCH_OP: mem_req SHALL be high, with mem_addr held stable, until mem_ready is sampled high on a rising edge.
REQ-022 At that edge, FETCH SHALL capture mem_rdata into ir and go to DECODE; FETCH_OP SHALL capture it into the target register and go to JUMP.
REQ-023 DECODE NOP: incr_pc=1 for one cycle, icount+1, then next-state selection.
REQ-024 DECODE JMP: incr_pc=1 for one cycle, then FETCH_OP.
REQ-025 JUMP: load_pc=1 for one cycle with addr=target, icount+1, then next-state selection.
REQ-026 DECODE HALT: no PC change, icount+1, go to HALT with err=0.
REQ-027 DECODE illegal: no PC change, go to HALT with err=1; icount SHALL be unchanged.
REQ-028 Next-state selection: FETCH if run=1, else IDLE; a running instruction SHALL always complete before IDLE is entered.
REQ-029 A wait counter SHALL restart on entry to FETCH or FETCH_OP; if mem_ready has not arrived after TIMEOUT cycles, go to HALT with err=1 and drop mem_req.
REQ-030 HALT SHALL be terminal until reset; step and run SHALL be ignored; halted=1.
REQ-031 load_pc and incr_pc SHALL never be high in the same cycle; each is a single-cycle pulse.
REQ-032 JMP opcode at pc=0xFF: the operand SHALL be fetched from 0x00 (PC wrap); icount SHALL wrap 0xFF to 0x00.
REQ-033 All outputs other than mem_addr and addr SHALL be registered or decoded from state only.
REQ-034 A step pulse that arrives outside IDLE SHALL be ignored, not queued.

Reset
REQ-035 When reset=1 at a rising edge, the state SHALL go to IDLE, with mem_req, load_pc, incr_pc, halted and err at 0, and ir, target (addr), icount and the wait counter at 0x00.
REQ-036 Reset SHALL take priority over every other input, including reset mid-fetch with mem_ready high on the same edge.

Structure
REQ-037 Package fetch_ctrl_pkg SHALL hold the state enum, the opcode constants OP_NOP, OP_JMP, OP_ILL and OP_HALT, and the default TIMEOUT.
REQ-038 No sub-module SHALL be used; fetch_ctrl SHALL be a single FSM plus counters, instantiated beside pc in the board top level.

Verification
REQ-039 Memory {0x00:NOP, 0x01:NOP, 0x02:HALT}, run=1, mem_ready always high -> pc goes 0,1,2; halted=1, err=0, icount=3.
REQ-040 Memory {0x00:0x40, 0x01:0x10, 0x10:HALT} -> one load_pc pulse with addr=0x10; pc ends at 0x10; icount=2.
REQ-041 run=0, three step pulses over NOP code -> pc=3, icount=3; IDLE after each step; a step pulse issued mid-instruction is ignored.
REQ-042 mem_ready held low, TIMEOUT=15 -> exactly 15 cycles after mem_req rises, halted=1, err=1, mem_req=0.
REQ-043 Opcode 0x80 at 0x00 -> halted=1, err=1, icount=0, and no PC pulse.
REQ-044 JMP at 0xFF with operand 0x05 at 0x00, then reset asserted during the following fetch -> PC reaches 0x05, then IDLE with all outputs at reset values on the next edge.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The opcode lives in the top two bits of the fetched byte.
package fetch_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      DECODE   = 3'd2,
      FETCH_OP = 3'd3,
      JUMP     = 3'd4,
      HALT     = 3'd5
   } state_t;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_JMP  = 2'b01;
   localparam logic [1:0] OP_ILL  = 2'b10;
   localparam logic [1:0] OP_HALT = 2'b11;

   localparam int unsigned TIMEOUT_DEFAULT = 15;

   function automatic logic [1:0] opcode_of(input logic [7:0] instr);
      return instr[7:6];
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch/decode controller driving an external program counter: fetches opcode
// bytes, handles one-byte NOP/HALT and two-byte JMP, and halts on errors.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   input  logic [7:0] pc,
   input  logic       mem_ready,
   input  logic [7:0] mem_rdata,
   output logic       mem_req,
   output logic [7:0] mem_addr,
   output logic       load_pc,
   output logic       incr_pc,
   output logic [7:0] addr,
   output logic [7:0] ir,
   output logic       halted,
   output logic       err,
   output logic [7:0] icount,
   output state_t     dbg_state
);

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] target_q, target_d;
   logic [7:0] icount_q, icount_d;
   logic [7:0] wait_q, wait_d;
   logic       err_q, err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         ir_q     <= 8'h00;
         target_q <= 8'h00;
         icount_q <= 8'h00;
         wait_q   <= 8'h00;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         target_q <= target_d;
         icount_q <= icount_d;
         wait_q   <= wait_d;
         err_q    <= err_d;
      end
   end

   // The wait counter only advances while a fetch is stalled; every other
   // path clears it, so entry to FETCH/FETCH_OP always starts from zero.
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      target_d = target_q;
      icount_d = icount_q;
      err_d    = err_q;
      wait_d   = 8'h00;
      case (state_q)
         IDLE: begin
            if (run || step) state_d = FETCH;
         end
         FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               state_d = DECODE;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         FETCH_OP: begin
            if (mem_ready) begin
               target_d = mem_rdata;
               state_d  = JUMP;
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = HALT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         DECODE: begin
            case (opcode_of(ir_q))
               OP_NOP: begin
                  icount_d = icount_q + 8'd1;
                  state_d  = run ? FETCH : IDLE;
               end
               OP_JMP: begin
                  state_d = FETCH_OP;
               end
               OP_HALT: begin
                  icount_d = icount_q + 8'd1;
                  state_d  = HALT;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = HALT;
               end
            endcase
         end
         JUMP: begin
            icount_d = icount_q + 8'd1;
            state_d  = run ? FETCH : IDLE;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // PC strobes come from state plus the registered opcode, so they are glitch-free.
   assign mem_req   = (state_q == FETCH) || (state_q == FETCH_OP);
   assign mem_addr  = pc;
   assign incr_pc   = (state_q == DECODE) &&
                      ((opcode_of(ir_q) == OP_NOP) || (opcode_of(ir_q) == OP_JMP));
   assign load_pc   = (state_q == JUMP);
   assign addr      = target_q;
   assign ir        = ir_q;
   assign halted    = (state_q == HALT);
   assign err       = err_q;
   assign icount    = icount_q;
   assign dbg_state = state_q;

endmodule
